note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Upstream stage of the square-wave tone generator.
- Accepts 6-bit note codes over a valid/ready handshake and queues them in a small FIFO.
- Plays each note as a silent gap followed by a sounding window, with the duration class decoded from the code.
- Drives the tone generator with a half-period count and a tone-enable flag.

Parameters:
- DEPTH, 8, FIFO depth in note codes; power of 2, minimum 2.
- TICK_16_GAP, 2500000, silent-gap clock cycles for a sixteenth note.
- TICK_16_TOTAL, 12500000, total clock cycles (gap plus play) for a sixteenth note; must be greater than TICK_16_GAP.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous reset, active-high.
- in_code  in  6  note code.
- in_valid  in  1  in_code is valid this cycle.
- in_ready  out  1  FIFO can accept a code; equals ~full & ~rst.
- half_period  out  32  half-period count for the tone generator; 0 means silent.
- tone_on  out  1  tone generator enabled.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- note_done  out  1  one-cycle pulse on the last cycle of each note.

Behaviour:
- Reset: FIFO empty, FSM in IDLE, half_period=0, tone_on=0, note_done=0, busy=0, duration counter=0.
- Push: a code is accepted on a cycle where in_valid & in_ready. in_valid while full is ignored and the code is dropped; the source must hold it.
- Simultaneous push and pop is legal at any occupancy except full. When full, in_ready=0, so only the pop occurs.
- Code decode:
  - 0 = rest, eighth.
  - 1-7 = mid do..si eighth; 8-14 mid quarter; 15-21 mid sixteenth.
  - 22-28 = low do..si eighth; 29-35 low quarter; 36-42 low sixteenth.
  - 43-49 = high do..si eighth; 50-56 high quarter; 57-63 high sixteenth.
- Half-period values:
  - low: 190840 170068 151515 143266 127551 113636 101215.
  - mid: 95602 85179 75873 71633 63776 56818 50607.
  - high: 47801 42553 37936 35791 31888 28409 25304.
- Duration multiplier M: sixteenth=1, eighth=2, quarter=4.
  - GAP = M*TICK_16_GAP.
  - TOTAL = M*TICK_16_TOTAL.
  - Products are 32-bit unsigned.
- FSM states IDLE, GAP, PLAY; counter cnt is 32 bits.
  - IDLE: if the FIFO is non-empty, pop, latch the decoded half-period/GAP/TOTAL, cnt=0, go to GAP.
  - GAP: tone_on=0, half_period=0, cnt increments. On cnt==GAP-1, go to PLAY with cnt=GAP.
  - PLAY: half_period=latched value, tone_on=(code!=0), cnt increments.
  - End of note: on cnt==TOTAL-1, assert note_done that cycle. Then, if the FIFO is non-empty, pop and go straight to GAP with cnt=0 (no IDLE bubble); otherwise go to IDLE.
- Timing:
  - Note length is exactly TOTAL cycles in back-to-back operation.
  - A note started from IDLE has 1 cycle of pop latency.
  - half_period and tone_on are registered; they change 1 cycle after the state edge.
- A rest (code 0) runs the full FSM with tone_on=0 and half_period=0 throughout, and still pulses note_done.
- Reset asserted mid-note aborts immediately:
  - Outputs go to their reset values on the next edge.
  - FIFO contents are discarded.
  - No note_done pulse is issued.
- FIFO read/write pointers wrap modulo DEPTH; occupancy is tracked with an extra pointer bit.

Optional Feature:
- Macro PAUSE_EN.
- Defined: adds input pause (1 bit).
  - While pause=1, cnt holds, FSM holds, no pop occurs, and tone_on is forced to 0.
  - half_period keeps its value.
  - Pushes are still accepted.
  - Releasing pause resumes on the same cnt value.
- Not defined: no pause port; the sequencer always advances.

Test Plan (TICK_16_GAP=2, TICK_16_TOTAL=10, DEPTH=4):
- Reset, then push code 15 -> half_period goes 0 for 2 cycles, then 95602 with tone_on=1 for 8 cycles; note_done pulses on cycle 10 of the note; then IDLE with busy=0.
- Push 8, 22, 57 back-to-back -> note lengths 40, 20, 10 cycles with no gaps between notes; half_periods 95602, 190840, 47801; exactly 3 note_done pulses.
- Push code 0 -> tone_on=0 for 20 cycles; a single note_done pulse.
- Hold in_valid=1 with 6 codes while the first note plays -> in_ready drops once 4 codes are queued; no code is lost when in_valid is held; order is preserved.
- Assert rst for 1 cycle mid-PLAY of a quarter note with 2 codes queued -> next cycle tone_on=0, half_period=0, busy=0; the queued codes never play.
- With PAUSE_EN defined: pause=1 for 7 cycles mid-PLAY of code 1 -> tone_on=0 during the pause; the note ends 7 cycles later than without the pause.

Source files
------------

// File: rtl/note_sequencer.sv
// Note sequencer: queues 6-bit note codes and plays each as a silent gap
// followed by a sounding window, driving the square-wave tone generator.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   pause               (only with `define PAUSE_EN) freeze the note in place
//   in_code/in_valid    note code input, accepted when in_ready is high
//   in_ready            FIFO has room (~full & ~rst)
//   half_period         tone half-period count, 0 = silent (registered)
//   tone_on             tone generator enable (registered)
//   busy                note in progress or codes queued
//   note_done           one-cycle pulse on the last cycle of each note
//
// Optional feature macro: PAUSE_EN (adds the pause input).
module note_sequencer #(
    parameter int DEPTH         = 8,
    parameter int TICK_16_GAP   = 2500000,
    parameter int TICK_16_TOTAL = 12500000
) (
    input  logic        clk,
    input  logic        rst,
`ifdef PAUSE_EN
    input  logic        pause,
`endif
    input  logic [5:0]  in_code,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] half_period,
    output logic        tone_on,
    output logic        busy,
    output logic        note_done
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [31:0] G1 = TICK_16_GAP;
    localparam logic [31:0] G2 = G1 << 1;
    localparam logic [31:0] G4 = G1 << 2;
    localparam logic [31:0] T1 = TICK_16_TOTAL;
    localparam logic [31:0] T2 = T1 << 1;
    localparam logic [31:0] T4 = T1 << 2;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        PLAY
    } state_t;

    // ---------------- FIFO ----------------
    logic [5:0]  mem [DEPTH];
    logic [AW:0] wp, rp;
    logic        empty, full, push, pop;
    logic [5:0]  head;

    assign empty    = (wp == rp);
    assign full     = (wp[AW] != rp[AW]) &&
                      (wp[AW-1:0] == rp[AW-1:0]);
    assign in_ready = ~full & ~rst;
    assign push     = in_valid & in_ready;
    assign head     = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= in_code;
    end

    // ---------------- run gate ----------------
    logic run;
`ifdef PAUSE_EN
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif

    // ---------------- decode of FIFO head ----------------
    // oct: 0 low, 1 mid, 2 high, 3 rest; dur: 0 sixteenth, 1 eighth, 2 quarter
    logic [1:0] oct;
    logic [2:0] idx;
    logic [1:0] dur;

    always_comb begin
        oct = 2'd3;
        idx = 3'd0;
        dur = 2'd1;
        unique case (1'b1)
            (head == 6'd0): begin
                oct = 2'd3; dur = 2'd1;
            end
            (head >= 6'd1 && head <= 6'd7): begin
                oct = 2'd1; dur = 2'd1; idx = 3'(head - 6'd1);
            end
            (head >= 6'd8 && head <= 6'd14): begin
                oct = 2'd1; dur = 2'd2; idx = 3'(head - 6'd8);
            end
            (head >= 6'd15 && head <= 6'd21): begin
                oct = 2'd1; dur = 2'd0; idx = 3'(head - 6'd15);
            end
            (head >= 6'd22 && head <= 6'd28): begin
                oct = 2'd0; dur = 2'd1; idx = 3'(head - 6'd22);
            end
            (head >= 6'd29 && head <= 6'd35): begin
                oct = 2'd0; dur = 2'd2; idx = 3'(head - 6'd29);
            end
            (head >= 6'd36 && head <= 6'd42): begin
                oct = 2'd0; dur = 2'd0; idx = 3'(head - 6'd36);
            end
            (head >= 6'd43 && head <= 6'd49): begin
                oct = 2'd2; dur = 2'd1; idx = 3'(head - 6'd43);
            end
            (head >= 6'd50 && head <= 6'd56): begin
                oct = 2'd2; dur = 2'd2; idx = 3'(head - 6'd50);
            end
            (head >= 6'd57): begin
                oct = 2'd2; dur = 2'd0; idx = 3'(head - 6'd57);
            end
        endcase
    end

    function automatic logic [31:0] hp_of(input logic [1:0] o,
                                          input logic [2:0] i);
        logic [31:0] v;
        v = 32'd0;
        case ({o, i})
            {2'd0, 3'd0}: v = 32'd190840;
            {2'd0, 3'd1}: v = 32'd170068;
            {2'd0, 3'd2}: v = 32'd151515;
            {2'd0, 3'd3}: v = 32'd143266;
            {2'd0, 3'd4}: v = 32'd127551;
            {2'd0, 3'd5}: v = 32'd113636;
            {2'd0, 3'd6}: v = 32'd101215;
            {2'd1, 3'd0}: v = 32'd95602;
            {2'd1, 3'd1}: v = 32'd85179;
            {2'd1, 3'd2}: v = 32'd75873;
            {2'd1, 3'd3}: v = 32'd71633;
            {2'd1, 3'd4}: v = 32'd63776;
            {2'd1, 3'd5}: v = 32'd56818;
            {2'd1, 3'd6}: v = 32'd50607;
            {2'd2, 3'd0}: v = 32'd47801;
            {2'd2, 3'd1}: v = 32'd42553;
            {2'd2, 3'd2}: v = 32'd37936;
            {2'd2, 3'd3}: v = 32'd35791;
            {2'd2, 3'd4}: v = 32'd31888;
            {2'd2, 3'd5}: v = 32'd28409;
            {2'd2, 3'd6}: v = 32'd25304;
            default:      v = 32'd0;
        endcase
        return v;
    endfunction

    logic [31:0] hp_dec, gap_dec, tot_dec;

    always_comb begin
        hp_dec  = hp_of(oct, idx);
        gap_dec = (dur == 2'd0) ? G1 : (dur == 2'd1) ? G2 : G4;
        tot_dec = (dur == 2'd0) ? T1 : (dur == 2'd1) ? T2 : T4;
    end

    // ---------------- FSM ----------------
    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [31:0] hp_lat, gap_lat, tot_lat;
    logic [5:0]  code_lat;
    logic        load, note_end;
    logic [31:0] hp_d;
    logic        tone_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 32'd0;
            hp_lat      <= 32'd0;
            gap_lat     <= 32'd0;
            tot_lat     <= 32'd0;
            code_lat    <= 6'd0;
            half_period <= 32'd0;
            tone_on     <= 1'b0;
            wp          <= '0;
            rp          <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            half_period <= hp_d;
            tone_on     <= tone_d;
            if (load) begin
                hp_lat   <= hp_dec;
                gap_lat  <= gap_dec;
                tot_lat  <= tot_dec;
                code_lat <= head;
            end
            if (push) wp <= wp + {{AW{1'b0}}, 1'b1};
            if (pop)  rp <= rp + {{AW{1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pop      = 1'b0;
        load     = 1'b0;
        note_end = 1'b0;
        if (run) begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        load    = 1'b1;
                        cnt_n   = 32'd0;
                        state_n = GAP;
                    end
                end
                GAP: begin
                    cnt_n = cnt + 32'd1;
                    if (cnt == gap_lat - 32'd1) state_n = PLAY;
                end
                PLAY: begin
                    cnt_n = cnt + 32'd1;
                    if (cnt == tot_lat - 32'd1) begin
                        note_end = 1'b1;
                        cnt_n    = 32'd0;
                        if (!empty) begin
                            pop     = 1'b1;
                            load    = 1'b1;
                            state_n = GAP;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = 32'd0;
                end
            endcase
        end
    end

    // Sounding outputs follow the state one cycle later (registered above);
    // pause silences the tone but leaves the half-period in place.
    always_comb begin
        hp_d      = (state == PLAY) ? hp_lat : 32'd0;
        tone_d    = (state == PLAY) && (code_lat != 6'd0) && run;
        busy      = (state != IDLE) || !empty;
        note_done = note_end & ~rst;
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Testbench for note_sequencer: schedule-based model of note timing plus
// directed scenarios with hand-computed expectations.
module tb_note_sequencer;

    localparam int DEPTH = 4;
    localparam int TG    = 2;
    localparam int TT    = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  in_code;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] half_period;
    logic        tone_on;
    logic        busy;
    logic        note_done;
`ifdef PAUSE_EN
    logic        pause;
`endif

    always #5 clk = ~clk;

    note_sequencer #(
        .DEPTH(DEPTH),
        .TICK_16_GAP(TG),
        .TICK_16_TOTAL(TT)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef PAUSE_EN
        .pause(pause),
`endif
        .in_code(in_code),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .half_period(half_period),
        .tone_on(tone_on),
        .busy(busy),
        .note_done(note_done)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit model_on   = 1'b1;

    int low_t[7]  = '{190840, 170068, 151515, 143266, 127551, 113636, 101215};
    int mid_t[7]  = '{95602, 85179, 75873, 71633, 63776, 56818, 50607};
    int high_t[7] = '{47801, 42553, 37936, 35791, 31888, 28409, 25304};

    // note schedule since last reset
    int          n_acc[$];
    int          n_start[$];
    int          n_g[$];
    int          n_t[$];
    int          n_hp[$];
    logic [5:0]  n_code[$];
    int          last_end = 0;

    logic [31:0] done_hp[$];
    int          done_cyc[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d",
                     name, cyc, act, exp);
        end
    endtask

    function automatic void decode(input logic [5:0] c, output int g,
                                   output int t, output int hp);
        int k, grp, m;
        if (c == 6'd0) begin
            m  = 2;
            hp = 0;
        end else begin
            k   = int'(c) - 1;
            grp = k / 7;
            m   = (grp % 3 == 0) ? 2 : (grp % 3 == 1) ? 4 : 1;
            case (grp / 3)
                0:       hp = mid_t[k % 7];
                1:       hp = low_t[k % 7];
                default: hp = high_t[k % 7];
            endcase
        end
        g = m * TG;
        t = m * TT;
    endfunction

    function automatic int occ(input int c);
        int n = 0;
        foreach (n_acc[i])
            if (n_acc[i] <= c && c < n_start[i]) n++;
        return n;
    endfunction

    // model: accept at posedge, compare at negedge
    always begin
        @(posedge clk);
        if (rst === 1'b1) begin
            n_acc.delete(); n_start.delete(); n_g.delete();
            n_t.delete(); n_hp.delete(); n_code.delete();
            last_end = 0;
        end else if (model_on && in_valid && occ(cyc) < DEPTH) begin
            int g, t, hp, s, p;
            p = cyc + 1;
            decode(in_code, g, t, hp);
            s = (last_end > p + 1) ? last_end : p + 1;
            n_acc.push_back(p);
            n_start.push_back(s);
            n_g.push_back(g);
            n_t.push_back(t);
            n_hp.push_back(hp);
            n_code.push_back(in_code);
            last_end = s + t;
        end
        cyc++;
        @(negedge clk);
        if (note_done === 1'b1) begin
            done_hp.push_back(half_period);
            done_cyc.push_back(cyc);
        end
        if (model_on) begin
            logic [31:0] e_hp;
            logic e_tone, e_done, e_busy, e_rdy;
            e_hp = 0; e_tone = 0; e_done = 0; e_busy = 0;
            foreach (n_start[i]) begin
                int s;
                s = n_start[i];
                if (cyc >= s + n_g[i] + 1 && cyc <= s + n_t[i]) begin
                    e_hp   = n_hp[i];
                    e_tone = (n_code[i] != 6'd0);
                end
                if (cyc == s + n_t[i] - 1 && !rst) e_done = 1'b1;
                if (cyc >= s && cyc <= s + n_t[i] - 1) e_busy = 1'b1;
                if (n_acc[i] <= cyc && cyc < s) e_busy = 1'b1;
            end
            e_rdy = !rst && occ(cyc) < DEPTH;
            check("m_half_period", half_period, e_hp);
            check("m_tone_on", tone_on, e_tone);
            check("m_note_done", note_done, e_done);
            check("m_busy", busy, e_busy);
            check("m_in_ready", in_ready, e_rdy);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [5:0] c);
        in_valid = 1'b1;
        in_code  = c;
        step();
        in_valid = 1'b0;
    endtask

    task automatic timeout(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s timeout cyc=%0d", name, cyc);
    endtask

    task automatic wait_done(input int bound, output int t);
        int k = 0;
        while (note_done !== 1'b1 && k < bound) begin
            step();
            k++;
        end
        if (k >= bound) timeout("wait_done");
        t = cyc;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 300) begin
            step();
            k++;
        end
        if (k >= 300) timeout("wait_idle");
        step();
    endtask

    logic [5:0]  hold_codes[6] = '{6'd8, 6'd16, 6'd37, 6'd59, 6'd43, 6'd0};
    logic [31:0] hold_hp[6]    = '{32'd95602, 32'd85179, 32'd170068,
                                   32'd37936, 32'd47801, 32'd0};

    initial begin
        int t0, t1, k;
        int stalls[6];
        rst      = 1'b1;
        in_valid = 1'b0;
        in_code  = 6'd0;
`ifdef PAUSE_EN
        pause    = 1'b0;
`endif
        step();
        step();
        check("rst_half_period", half_period, 0);
        check("rst_tone_on", tone_on, 0);
        check("rst_busy", busy, 0);
        check("rst_note_done", note_done, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        step();

        // single sixteenth note
        push(6'd15);
        t0 = cyc;
        wait_done(50, t1);
        check("t1_done_latency", t1 - t0, 10);
        check("t1_hp_at_done", half_period, 95602);
        check("t1_tone_at_done", tone_on, 1);
        step();
        step();
        check("t1_idle_busy", busy, 0);
        check("t1_idle_hp", half_period, 0);
        step();

        // back-to-back quarter / eighth / sixteenth
        done_hp.delete();
        done_cyc.delete();
        in_valid = 1'b1;
        in_code  = 6'd8;
        step();
        t0 = cyc;
        in_code = 6'd22;
        step();
        in_code = 6'd57;
        step();
        in_valid = 1'b0;
        repeat (75) step();
        check("t2_done_count", done_cyc.size(), 3);
        if (done_cyc.size() == 3) begin
            check("t2_len1", done_cyc[0] - t0, 40);
            check("t2_len2", done_cyc[1] - done_cyc[0], 20);
            check("t2_len3", done_cyc[2] - done_cyc[1], 10);
            check("t2_hp1", done_hp[0], 95602);
            check("t2_hp2", done_hp[1], 190840);
            check("t2_hp3", done_hp[2], 47801);
        end
        wait_idle();

        // rest
        done_cyc.delete();
        push(6'd0);
        t0 = cyc;
        wait_done(60, t1);
        check("t3_rest_len", t1 - t0, 20);
        check("t3_rest_tone", tone_on, 0);
        repeat (3) step();
        check("t3_rest_pulses", done_cyc.size(), 1);
        wait_idle();

        // held in_valid against a full FIFO
        done_hp.delete();
        done_cyc.delete();
        foreach (hold_codes[i]) begin
            in_valid = 1'b1;
            in_code  = hold_codes[i];
            k = 0;
            while (in_ready !== 1'b1 && k < 300) begin
                step();
                k++;
            end
            if (k >= 300) timeout("t4_hold");
            stalls[i] = k;
            step();
        end
        in_valid = 1'b0;
        check("t4_no_stall_first5", stalls[0] + stalls[1] + stalls[2] +
              stalls[3] + stalls[4], 0);
        check("t4_stall_sixth", stalls[5] > 0, 1);
        wait_idle();
        check("t4_done_count", done_hp.size(), 6);
        if (done_hp.size() == 6)
            foreach (hold_hp[i]) check("t4_order_hp", done_hp[i], hold_hp[i]);

        // reset mid-PLAY of a quarter note with two codes queued
        push(6'd29);
        push(6'd1);
        push(6'd2);
        k = 0;
        while (tone_on !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        if (k >= 50) timeout("t5_tone");
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_tone_after_rst", tone_on, 0);
        check("t5_hp_after_rst", half_period, 0);
        check("t5_busy_after_rst", busy, 0);
        done_cyc.delete();
        repeat (80) step();
        check("t5_no_done", done_cyc.size(), 0);
        check("t5_still_idle", busy, 0);

`ifdef PAUSE_EN
        model_on = 1'b0;
        push(6'd1);
        t0 = cyc;
        repeat (10) step();
        pause = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            check("p_tone_paused", tone_on, 0);
            check("p_hp_held", half_period, 95602);
            step();
        end
        pause = 1'b0;
        wait_done(60, t1);
        check("p_done_latency", t1 - t0, 27);
        wait_idle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
